// File: rtl/sc_row_demux_bank_pkg.sv
// sc_row_demux_bank_pkg: shared op codes, FSM encodings and sizes for the row demux bank.
package sc_row_demux_bank_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_ROWS = 10;
  localparam int SEL_WIDTH = 4;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_ROT = 2'b11;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;
endpackage

// File: rtl/sc_row_demux_bank_row.sv
// sc_row_reg: one row register with op decode, write enable and synchronous clear.
// ROT support is compiled in with SC_ROW_DEMUX_BANK_ROTATE_EN.
module sc_row_reg
  import sc_row_demux_bank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  clr,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] nxt;
`ifdef SC_ROW_DEMUX_BANK_ROTATE_EN
  always_comb
    nxt = op == OP_LOAD ? data :
          op == OP_SET  ? q | data :
          op == OP_CLR  ? q & ~data :
          data[0]       ? {q[0], q[DATA_WIDTH-1:1]} : {q[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
`else
  // op 11 never reaches a row here; the top rejects it before we is raised
  always_comb
    nxt = op == OP_LOAD ? data :
          op == OP_SET  ? q | data :
          op == OP_CLR  ? q & ~data : q;
`endif
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : we ? nxt : q;
endmodule

// File: rtl/sc_row_demux_bank.sv
// sc_row_demux_bank: 1-to-10 row write demux with valid/ready handshake and clear sweep FSM.
// Define SC_ROW_DEMUX_BANK_ROTATE_EN to enable op 11 (ROT); otherwise op 11 is rejected.
module sc_row_demux_bank
  import sc_row_demux_bank_pkg::*;
(
  input  logic                  SC_ROW_DEMUX_BANK_CLOCK_50,
  input  logic                  SC_ROW_DEMUX_BANK_RESET_InHigh,
  input  logic                  SC_ROW_DEMUX_BANK_valid_In,
  output logic                  SC_ROW_DEMUX_BANK_ready_Out,
  input  logic [SEL_WIDTH-1:0]  SC_ROW_DEMUX_BANK_select_InBUS,
  input  logic [1:0]            SC_ROW_DEMUX_BANK_op_InBUS,
  input  logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_InBUS,
  input  logic                  SC_ROW_DEMUX_BANK_clear_In,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_0,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_1,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_2,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_3,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_4,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_5,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_6,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_7,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_8,
  output logic [DATA_WIDTH-1:0] SC_ROW_DEMUX_BANK_data_OutBUS_9,
  output logic                  SC_ROW_DEMUX_BANK_busy_Out,
  output logic                  SC_ROW_DEMUX_BANK_error_Out
);
  logic clk, rst;
  logic [0:0] state;
  logic [SEL_WIDTH-1:0] sweepCnt;
  logic accept, badOp, reject, writeOk, errorReg;
  logic [DATA_WIDTH-1:0] rowQ [NUM_ROWS];
  assign clk = SC_ROW_DEMUX_BANK_CLOCK_50;
  assign rst = SC_ROW_DEMUX_BANK_RESET_InHigh;
  // clear takes priority over a write presented in the same cycle
  assign SC_ROW_DEMUX_BANK_ready_Out = state == ST_IDLE && !SC_ROW_DEMUX_BANK_clear_In && !rst;
  assign accept = SC_ROW_DEMUX_BANK_valid_In && SC_ROW_DEMUX_BANK_ready_Out;
`ifdef SC_ROW_DEMUX_BANK_ROTATE_EN
  assign badOp = 1'b0;
`else
  assign badOp = SC_ROW_DEMUX_BANK_op_InBUS == OP_ROT;
`endif
  assign reject = accept && (SC_ROW_DEMUX_BANK_select_InBUS >= SEL_WIDTH'(NUM_ROWS) || badOp);
  assign writeOk = accept && !reject;
  assign SC_ROW_DEMUX_BANK_busy_Out = state == ST_SWEEP;
  assign SC_ROW_DEMUX_BANK_error_Out = errorReg;
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      sweepCnt <= '0;
      errorReg <= 1'b0;
    end else begin
      errorReg <= reject;
      state <= state == ST_IDLE ? (SC_ROW_DEMUX_BANK_clear_In ? ST_SWEEP : ST_IDLE)
                                : (sweepCnt == SEL_WIDTH'(NUM_ROWS - 1) ? ST_IDLE : ST_SWEEP);
      sweepCnt <= state == ST_IDLE ? '0 : sweepCnt + 1'b1;
    end
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    sc_row_reg u_row (
      .clk (clk),
      .rst (rst),
      .we  (writeOk && SC_ROW_DEMUX_BANK_select_InBUS == SEL_WIDTH'(i)),
      .clr (state == ST_SWEEP && sweepCnt == SEL_WIDTH'(i)),
      .op  (SC_ROW_DEMUX_BANK_op_InBUS),
      .data(SC_ROW_DEMUX_BANK_data_InBUS),
      .q   (rowQ[i])
    );
  end
  assign SC_ROW_DEMUX_BANK_data_OutBUS_0 = rowQ[0];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_1 = rowQ[1];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_2 = rowQ[2];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_3 = rowQ[3];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_4 = rowQ[4];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_5 = rowQ[5];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_6 = rowQ[6];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_7 = rowQ[7];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_8 = rowQ[8];
  assign SC_ROW_DEMUX_BANK_data_OutBUS_9 = rowQ[9];
endmodule

// File: tb/tb_sc_row_demux_bank.sv
// tb_sc_row_demux_bank: directed self-checking bench for sc_row_demux_bank.
// Honors SC_ROW_DEMUX_BANK_ROTATE_EN to pick the expected ROT behaviour.
module tb_sc_row_demux_bank;
  logic clk = 1'b0, rst = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [3:0] sel = '0;
  logic [1:0] op = '0;
  logic [7:0] data = '0;
  logic ready, busy, err;
  logic [7:0] row [10];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sc_row_demux_bank dut (
    .SC_ROW_DEMUX_BANK_CLOCK_50     (clk),
    .SC_ROW_DEMUX_BANK_RESET_InHigh (rst),
    .SC_ROW_DEMUX_BANK_valid_In     (valid),
    .SC_ROW_DEMUX_BANK_ready_Out    (ready),
    .SC_ROW_DEMUX_BANK_select_InBUS (sel),
    .SC_ROW_DEMUX_BANK_op_InBUS     (op),
    .SC_ROW_DEMUX_BANK_data_InBUS   (data),
    .SC_ROW_DEMUX_BANK_clear_In     (clear),
    .SC_ROW_DEMUX_BANK_data_OutBUS_0(row[0]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_1(row[1]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_2(row[2]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_3(row[3]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_4(row[4]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_5(row[5]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_6(row[6]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_7(row[7]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_8(row[8]),
    .SC_ROW_DEMUX_BANK_data_OutBUS_9(row[9]),
    .SC_ROW_DEMUX_BANK_busy_Out     (busy),
    .SC_ROW_DEMUX_BANK_error_Out    (err)
  );

  // Presents one write at the current negedge and advances through one rising edge.
  task automatic write(input logic [3:0] s, input logic [1:0] o, input logic [7:0] d);
    valid = 1'b1;
    sel = s;
    op = o;
    data = d;
    @(negedge clk);
  endtask

  task automatic idle();
    valid = 1'b0;
    clear = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low got %b want 0", ready); end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (row[k] !== 8'h00) begin miscompares++; $display("FAIL reset_row%0d got %h want 00", k, row[k]); end
    end
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_busy_err got %b%b want 00", busy, err); end
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_high got %b want 1", ready); end
  endtask

  task automatic test_ops();
    logic [7:0] exp [3] = '{8'hA5, 8'hAF, 8'h2E};
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b10};
    logic [7:0] dat [3] = '{8'hA5, 8'h0F, 8'h81};
    for (int i = 0; i < 3; i++) begin
      write(4'd3, ops[i], dat[i]);
      vectors++;
      if (row[3] !== exp[i]) begin miscompares++; $display("FAIL op%0d_row3 got %h want %h", i, row[3], exp[i]); end
    end
    idle();
    for (int k = 0; k < 10; k++) if (k != 3) begin
      vectors++;
      if (row[k] !== 8'h00) begin miscompares++; $display("FAIL ops_other_row%0d got %h want 00", k, row[k]); end
    end
  endtask

  task automatic test_invalid();
    write(4'd12, 2'b00, 8'hFF);
    idle();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL invalid_err_pulse got %b want 1", err); end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (row[k] !== (k == 3 ? 8'h2E : 8'h00)) begin miscompares++; $display("FAIL invalid_row%0d got %h", k, row[k]); end
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL invalid_err_clear got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    write(4'd5, 2'b00, 8'h30);
    vectors++;
    if (row[5] !== 8'h30) begin miscompares++; $display("FAIL b2b_load got %h want 30", row[5]); end
    write(4'd5, 2'b01, 8'h03);
    vectors++;
    if (row[5] !== 8'h33) begin miscompares++; $display("FAIL b2b_set got %h want 33", row[5]); end
    write(4'd5, 2'b10, 8'h10);
    vectors++;
    if (row[5] !== 8'h23) begin miscompares++; $display("FAIL b2b_clr got %h want 23", row[5]); end
    write(4'd6, 2'b00, 8'h11);
    idle();
    vectors++;
    if (row[6] !== 8'h11 || row[5] !== 8'h23) begin miscompares++; $display("FAIL b2b_row6 got %h/%h want 11/23", row[6], row[5]); end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 10; k++) write(4'(k), 2'b00, 8'hFF);
    valid = 1'b1;
    clear = 1'b1;
    sel = 4'd9;
    op = 2'b00;
    data = 8'h55;
    #1;
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL sweep_ready_on_clear got %b want 0", ready); end
    @(negedge clk);
    idle();
    vectors++;
    if (row[9] !== 8'hFF) begin miscompares++; $display("FAIL sweep_write_blocked got %h want ff", row[9]); end
    for (int k = 0; k < 10; k++) begin
      clear = (k == 5);
      #1;
      vectors++;
      if (busy !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL sweep%0d_busy_ready got %b%b want 10", k, busy, ready); end
      @(negedge clk);
      vectors++;
      if (row[k] !== 8'h00) begin miscompares++; $display("FAIL sweep%0d_cleared got %h want 00", k, row[k]); end
      if (k < 9) begin
        vectors++;
        if (row[k+1] !== 8'hFF) begin miscompares++; $display("FAIL sweep%0d_next_held got %h want ff", k, row[k+1]); end
      end
    end
    clear = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL sweep_done got %b%b want 01", busy, ready); end
  endtask

  task automatic test_reset_sweep();
    write(4'd2, 2'b00, 8'h44);
    write(4'd8, 2'b00, 8'h88);
    idle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || row[8] !== 8'h88) begin miscompares++; $display("FAIL rstsweep_pre got %b/%h want 1/88", busy, row[8]); end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (row[k] !== 8'h00) begin miscompares++; $display("FAIL rstsweep_row%0d got %h want 00", k, row[k]); end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rstsweep_busy got %b want 0", busy); end
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL rstsweep_ready got %b want 1", ready); end
  endtask

  task automatic test_rot();
`ifdef SC_ROW_DEMUX_BANK_ROTATE_EN
    logic [7:0] expLeft = 8'h03;
    logic expErr = 1'b0;
`else
    logic [7:0] expLeft = 8'h81;
    logic expErr = 1'b1;
`endif
    write(4'd7, 2'b00, 8'h81);
    write(4'd7, 2'b11, 8'h00);
    idle();
    vectors++;
    if (row[7] !== expLeft || err !== expErr) begin miscompares++; $display("FAIL rot_left got %h/%b want %h/%b", row[7], err, expLeft, expErr); end
    write(4'd7, 2'b11, 8'h01);
    idle();
    vectors++;
    if (row[7] !== 8'h81 || err !== expErr) begin miscompares++; $display("FAIL rot_right got %h/%b want 81/%b", row[7], err, expErr); end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL rot_err_clear got %b want 0", err); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ops();
    test_invalid();
    test_back_to_back();
    test_sweep();
    test_reset_sweep();
    test_rot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
